// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CPU constants, next-PC selector codes and fetch FSM encoding
package cpu_defs_pkg;
    localparam logic [1:0]  NPC_PC4  = 2'b00;
    localparam logic [1:0]  NPC_JAL  = 2'b10;
    localparam logic [1:0]  NPC_JALR = 2'b11;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_VALID,
        FS_FAULT
    } fetch_state_t;
endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC selection for the retiring instruction
import cpu_defs_pkg::*;
module npc_calc (
    input  logic [31:0] id_pc,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] alu_res,
    output logic [31:0] npc,
    output logic        misalign
);
    assign npc = (npc_op == NPC_JALR) ? (alu_res & ~32'h1) :
                 (npc_op == NPC_JAL || branch_taken) ? id_pc + imm : id_pc + 32'd4;
    assign misalign = |npc[1:0];
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: non-speculative single-outstanding instruction fetch with PC update and retire count
import cpu_defs_pkg::*;
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic [6:0]       opcode,
    output logic [2:0]       fun3,
    output logic [6:0]       fun7,
    input  logic [1:0]       npc_op,
    input  logic             branch_taken,
    input  logic [31:0]      imm,
    input  logic [31:0]      alu_res,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] retired_cnt
);
    fetch_state_t state, state_nxt;
    logic [31:0] pc, npc;
    logic        misalign, accept;

    assign accept = (state == FS_VALID) && id_ready;

    npc_calc u_npc_calc (
        .id_pc        (pc),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .imm          (imm),
        .alu_res      (alu_res),
        .npc          (npc),
        .misalign     (misalign)
    );

    // fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_IDLE;
        else        state <= state_nxt;
    end

    // fetch FSM next state: one request in flight, next fetch only after accept
    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE:  state_nxt = FS_REQ;
            FS_REQ:   state_nxt = FS_WAIT;
            FS_WAIT:  state_nxt = imem_rvalid ? FS_VALID : FS_WAIT;
            FS_VALID: state_nxt = !id_ready ? FS_VALID : (misalign ? FS_FAULT : FS_REQ);
            FS_FAULT: state_nxt = FS_FAULT;
            default:  state_nxt = FS_IDLE;
        endcase
    end

    // PC, captured instruction, sticky fault and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            id_inst     <= NOP_INST;
            fetch_fault <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (state == FS_WAIT && imem_rvalid) id_inst <= imem_rdata;
            if (accept) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
                if (misalign) fetch_fault <= 1'b1;
                else          pc <= npc;
            end
        end
    end

    assign imem_req  = (state == FS_REQ);
    assign imem_addr = pc;
    assign id_valid  = (state == FS_VALID);
    assign id_pc     = pc;
    assign id_pc4    = pc + 32'd4;
    assign opcode    = id_inst[6:0];
    assign fun3      = id_inst[14:12];
    assign fun7      = id_inst[31:25];
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized checks of ifetch_unit against a transaction-level model
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_rvalid, id_valid, id_ready, branch_taken, fetch_fault;
    logic [31:0] imem_addr, imem_rdata, id_inst, id_pc, id_pc4, imm, alu_res, retired_cnt;
    logic [6:0]  opcode, fun7;
    logic [2:0]  fun3;
    logic [1:0]  npc_op;

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
        .opcode(opcode), .fun3(fun3), .fun7(fun7), .npc_op(npc_op),
        .branch_taken(branch_taken), .imm(imm), .alu_res(alu_res),
        .fetch_fault(fetch_fault), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0, cyc = 0;
    bit m_idle, m_req, m_out, m_valid, m_fault;
    logic [31:0] m_pc, m_inst, m_cnt;
    bit rand_mode = 0, spur = 0, pend = 0, ok;
    int lat_cnt = 0, dir_lat = 1;
    logic [31:0] dir_word = 32'h0050_0093, cur_word, a, s_inst, s_pc;
    logic [31:0] req_addr_q[$];
    int req_cyc_q[$];
    int c0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_npc(input logic [31:0] pc, input logic [1:0] op,
                                          input logic bt, input logic [31:0] im, input logic [31:0] alu);
        if (op == 2'b11) return {alu[31:1], 1'b0};
        if (op == 2'b10 || bt) return pc + im;
        return pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_idle = 1; m_req = 0; m_out = 0; m_valid = 0; m_fault = 0;
        m_pc = 32'h0; m_inst = 32'h0000_0013; m_cnt = 0;
    endtask

    task automatic model_update();
        logic [31:0] n;
        if (!rst_n) begin model_reset(); return; end
        if (m_fault) ;
        else if (m_idle) begin m_idle = 0; m_req = 1; end
        else if (m_req) begin m_req = 0; m_out = 1; end
        else if (m_out) begin
            if (imem_rvalid) begin m_out = 0; m_valid = 1; m_inst = imem_rdata; end
        end else if (m_valid && id_ready) begin
            m_cnt++;
            m_valid = 0;
            n = m_npc(m_pc, npc_op, branch_taken, imm, alu_res);
            if (n[1:0] != 2'b00) m_fault = 1;
            else begin m_pc = n; m_req = 1; end
        end
    endtask

    task automatic compare();
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", id_valid, m_valid);
        chk("id_inst", id_inst, m_inst);
        chk("id_pc", id_pc, m_pc);
        chk("id_pc4", id_pc4, m_pc + 32'd4);
        chk("opcode", opcode, m_inst[6:0]);
        chk("fun3", fun3, m_inst[14:12]);
        chk("fun7", fun7, m_inst[31:25]);
        chk("fetch_fault", fetch_fault, m_fault);
        chk("retired_cnt", retired_cnt, m_cnt);
    endtask

    task automatic cycle();
        logic [31:0] r, r2;
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        compare();
        imem_rvalid = 0;
        imem_rdata = $urandom;
        if (pend) begin
            lat_cnt--;
            if (lat_cnt == 0) begin imem_rvalid = 1; imem_rdata = cur_word; pend = 0; end
        end else if (spur && $urandom_range(7) == 0) imem_rvalid = 1;
        if (imem_req) begin
            req_addr_q.push_back(imem_addr);
            req_cyc_q.push_back(cyc);
            pend = 1;
            lat_cnt = rand_mode ? int'($urandom_range(4, 1)) : dir_lat;
            cur_word = rand_mode ? $urandom : dir_word;
        end
        if (rand_mode) begin
            r = $urandom; r2 = $urandom;
            id_ready = ($urandom_range(9) < 7);
            npc_op = 2'($urandom_range(3));
            branch_taken = 1'($urandom_range(1));
            imm = {{20{r[11]}}, r[11:2], ($urandom_range(15) == 0) ? r[1:0] : 2'b00};
            alu_res = {r2[31:2], ($urandom_range(15) == 0), r2[0]};
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        pend = 0;
        #1;
        model_reset();
        compare();
        cycle();
        rst_n = 1;
    endtask

    task automatic wait_valid(output bit got);
        got = id_valid;
        for (int i = 0; i < 20 && !got; i++) begin cycle(); got = id_valid; end
        if (!got) begin vecs++; errs++; $display("FAIL wait_valid: id_valid=0 after 20 cycles, required 1"); end
    endtask

    task automatic next_req(output logic [31:0] addr);
        bit got;
        got = imem_req;
        for (int i = 0; i < 20 && !got; i++) begin cycle(); got = imem_req; end
        if (!got) begin vecs++; errs++; $display("FAIL next_req: imem_req=0 after 20 cycles, required 1"); end
        addr = imem_addr;
    endtask

    task automatic accept_with(input logic [1:0] op, input logic bt, input logic [31:0] im, input logic [31:0] alu);
        bit got;
        wait_valid(got);
        npc_op = op; branch_taken = bt; imm = im; alu_res = alu; id_ready = 1;
        cycle();
        id_ready = 0; npc_op = 0; branch_taken = 0;
    endtask

    initial begin
        rst_n = 1; imem_rvalid = 0; imem_rdata = 0; id_ready = 0;
        npc_op = 0; branch_taken = 0; imm = 0; alu_res = 0;
        model_reset();
        #2;
        // sequential fetch: 0,4,8 every 3 cycles, three retires
        do_reset();
        chk("t1_reset_inst", id_inst, 32'h0000_0013);
        req_addr_q.delete(); req_cyc_q.delete();
        for (int i = 0; i < 3; i++) accept_with(2'b00, 0, 0, 0);
        chk("t1_addr0", req_addr_q[0], 32'h0);
        chk("t1_addr1", req_addr_q[1], 32'h4);
        chk("t1_addr2", req_addr_q[2], 32'h8);
        chk("t1_gap1", 32'(req_cyc_q[1] - req_cyc_q[0]), 32'd3);
        chk("t1_gap2", 32'(req_cyc_q[2] - req_cyc_q[1]), 32'd3);
        chk("t1_cnt", retired_cnt, 32'd3);
        // hold in VALID for 5 cycles
        wait_valid(ok);
        s_inst = id_inst; s_pc = id_pc;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_inst", id_inst, s_inst);
            chk("t2_pc", id_pc, s_pc);
            chk("t2_noreq", imem_req, 0);
        end
        chk("t2_pc_lit", id_pc, 32'hC);
        chk("t2_opcode", opcode, 7'h13);
        chk("t2_fun3", fun3, 0);
        chk("t2_fun7", fun7, 0);
        accept_with(2'b00, 0, 0, 0);
        // branch and jal targets
        accept_with(2'b00, 1, 32'hFFFF_FFF8, 0);
        next_req(a); chk("t3_branch", a, 32'h8);
        accept_with(2'b10, 0, 32'h100, 0);
        next_req(a); chk("t3_jal", a, 32'h108);
        // jalr clears bit 0, misaligned jalr faults
        accept_with(2'b11, 0, 0, 32'h2001);
        next_req(a); chk("t4_jalr", a, 32'h2000);
        accept_with(2'b11, 0, 0, 32'h2002);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t4_fault", fetch_fault, 1);
            chk("t4_noreq", imem_req, 0);
            chk("t4_novalid", id_valid, 0);
            chk("t4_pc", imem_addr, 32'h2000);
        end
        // slow IROM and spurious rvalid in VALID
        do_reset();
        dir_lat = 4;
        next_req(a);
        c0 = cyc;
        wait_valid(ok);
        chk("t5_latency", 32'(cyc - c0), 32'd5);
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("t5_spur_inst", id_inst, 32'h0050_0093);
        chk("t5_spur_valid", id_valid, 1);
        // reset during WAIT with a late rvalid after release
        dir_lat = 1;
        accept_with(2'b00, 0, 0, 0);
        dir_lat = 4;
        next_req(a); chk("t6_addr_pre", a, 32'h4);
        cycle();
        do_reset();
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_cnt", retired_cnt, 0);
        chk("t6_inst", id_inst, 32'h0000_0013);
        chk("t6_valid", id_valid, 0);
        imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
        cycle();
        chk("t6_req", imem_req, 1);
        chk("t6_req_addr", imem_addr, 32'h0);
        wait_valid(ok);
        chk("t6_inst_after", id_inst, 32'h0050_0093);
        // PC wraps at 2^32
        do_reset();
        dir_lat = 1;
        accept_with(2'b11, 0, 0, 32'hFFFF_FFFC);
        next_req(a); chk("t7_top", a, 32'hFFFF_FFFC);
        accept_with(2'b00, 0, 0, 0);
        next_req(a); chk("t7_wrap", a, 32'h0);
        // randomized traffic against the model
        rand_mode = 1; spur = 1;
        for (int i = 0; i < 4000; i++) begin
            cycle();
            if (m_fault ? ($urandom_range(7) == 0) : ($urandom_range(299) == 0)) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
